// File: rtl/lm32_m_result_stage_pkg.sv
// Shared encodings and word/register-index types for the LM32 M-stage result path.
package lm32_m_result_stage_pkg;

   localparam int LM32_WORD_WIDTH    = 32;
   localparam int LM32_REG_IDX_WIDTH = 5;

   typedef logic [LM32_WORD_WIDTH-1:0]    lm32_word_t;
   typedef logic [LM32_REG_IDX_WIDTH-1:0] lm32_reg_idx_t;

   typedef enum logic [1:0] {
      RESULT_SEL_OPERAND = 2'b00,
      RESULT_SEL_SHIFT   = 2'b01,
      RESULT_SEL_MUL     = 2'b10,
      RESULT_SEL_LOAD    = 2'b11
   } result_sel_e;

   typedef enum logic [1:0] {
      LOAD_BYTE = 2'b00,
      LOAD_HALF = 2'b01,
      LOAD_WORD = 2'b10,
      LOAD_RSVD = 2'b11
   } load_size_e;

endpackage

// File: rtl/lm32_load_align.sv
// Big-endian lane selection and sign/zero extension of a raw data-bus word.
module lm32_load_align
   import lm32_m_result_stage_pkg::*;
(
   input  logic [31:0] load_data_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [1:0]  addr_lsb_i,
   output logic [31:0] aligned_o
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   // Lane 0 of the address is the most significant byte of the bus word.
   always_comb begin
      byteLane = 8'h00;
      case (addr_lsb_i)
         2'b00:   byteLane = load_data_i[31:24];
         2'b01:   byteLane = load_data_i[23:16];
         2'b10:   byteLane = load_data_i[15:8];
         default: byteLane = load_data_i[7:0];
      endcase
      halfLane = addr_lsb_i[1] ? load_data_i[15:0] : load_data_i[31:16];
   end

   always_comb begin
      aligned_o = load_data_i;
      case (load_size_e'(size_i))
         LOAD_BYTE: aligned_o = {{24{sign_i & byteLane[7]}}, byteLane};
         LOAD_HALF: aligned_o = {{16{sign_i & halfLane[15]}}, halfLane};
         default:   aligned_o = load_data_i;
      endcase
   end

endmodule

// File: rtl/lm32_m_result_stage.sv
// M-stage result mux, bypass/interlock generation and the M-to-W pipeline register.
module lm32_m_result_stage
   import lm32_m_result_stage_pkg::*;
#(
   parameter bit MULTIPLIER_ENABLED = 1'b1,
   parameter bit BYPASS_ENABLED     = 1'b1
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_m,
   input  logic        kill_m,
   input  logic        valid_m,
   input  logic        write_enable_m,
   input  logic [4:0]  write_idx_m,
   input  logic [1:0]  result_sel_m,
   input  logic [31:0] operand_m,
   input  logic [31:0] shifter_result_m,
   input  logic [31:0] multiplier_result_m,
   input  logic [31:0] load_data_m,
   input  logic [1:0]  load_size_m,
   input  logic        load_sign_extend_m,
   input  logic [1:0]  addr_lsb_m,
   output logic [31:0] bypass_data_m,
   output logic        bypass_valid_m,
   output logic        interlock_m,
   output logic [31:0] result_w,
   output logic [4:0]  write_idx_w,
   output logic        write_enable_w,
   output logic        valid_w
);

   lm32_word_t    loadAligned;
   lm32_word_t    resultM;
   lm32_word_t    result_d, result_q;
   lm32_reg_idx_t writeIdx_d, writeIdx_q;
   logic          writeEnable_d, writeEnable_q;
   logic          valid_d, valid_q;
   logic          isLoad;

   lm32_load_align uLoadAlign (
      .load_data_i (load_data_m),
      .size_i      (load_size_m),
      .sign_i      (load_sign_extend_m),
      .addr_lsb_i  (addr_lsb_m),
      .aligned_o   (loadAligned)
   );

   always_comb begin
      resultM = operand_m;
      case (result_sel_e'(result_sel_m))
         RESULT_SEL_OPERAND: resultM = operand_m;
         RESULT_SEL_SHIFT:   resultM = shifter_result_m;
         RESULT_SEL_MUL:     resultM = MULTIPLIER_ENABLED ? multiplier_result_m : 32'h0;
         default:            resultM = loadAligned;
      endcase
   end

   // Load data is only ready at the end of M, so loads interlock instead of forwarding.
   assign isLoad         = (result_sel_m == RESULT_SEL_LOAD);
   assign interlock_m    = valid_m & write_enable_m & isLoad;
   assign bypass_valid_m = BYPASS_ENABLED & valid_m & write_enable_m & ~isLoad;
   assign bypass_data_m  = BYPASS_ENABLED ? resultM : 32'h0;

   always_comb begin
      result_d      = result_q;
      writeIdx_d    = writeIdx_q;
      valid_d       = 1'b0;
      writeEnable_d = 1'b0;
      if (!stall_m) begin
         result_d      = resultM;
         writeIdx_d    = write_idx_m;
         valid_d       = valid_m & ~kill_m;
         writeEnable_d = write_enable_m & valid_m & ~kill_m;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q      <= '0;
         writeIdx_q    <= '0;
         writeEnable_q <= 1'b0;
         valid_q       <= 1'b0;
      end else begin
         result_q      <= result_d;
         writeIdx_q    <= writeIdx_d;
         writeEnable_q <= writeEnable_d;
         valid_q       <= valid_d;
      end
   end

   assign result_w       = result_q;
   assign write_idx_w    = writeIdx_q;
   assign write_enable_w = writeEnable_q;
   assign valid_w        = valid_q;

endmodule

// File: tb/tb_lm32_m_result_stage.sv
// Directed, table-driven bench for lm32_m_result_stage plus stall, kill and async-reset sequences.
module tb_lm32_m_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_m, kill_m, valid_m, write_enable_m, load_sign_extend_m;
   logic [4:0]  write_idx_m;
   logic [1:0]  result_sel_m, load_size_m, addr_lsb_m;
   logic [31:0] operand_m, shifter_result_m, multiplier_result_m, load_data_m;

   logic [31:0] bypass_data_m, result_w;
   logic        bypass_valid_m, interlock_m, write_enable_w, valid_w;
   logic [4:0]  write_idx_w;

   logic [31:0] bypass_data_m2, result_w2;
   logic        bypass_valid_m2, interlock_m2, write_enable_w2, valid_w2;
   logic [4:0]  write_idx_w2;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic        valid, we, kill, sign;
      logic [4:0]  idx;
      logic [1:0]  sel, size, addr;
      logic [31:0] op, sh, mul, ld;
      logic        expBv, expIl, expVw, expWw;
      logic [31:0] expRw;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   lm32_m_result_stage dut (
      .clk_i(clk), .rst_i(rst), .stall_m(stall_m), .kill_m(kill_m), .valid_m(valid_m),
      .write_enable_m(write_enable_m), .write_idx_m(write_idx_m), .result_sel_m(result_sel_m),
      .operand_m(operand_m), .shifter_result_m(shifter_result_m),
      .multiplier_result_m(multiplier_result_m), .load_data_m(load_data_m),
      .load_size_m(load_size_m), .load_sign_extend_m(load_sign_extend_m), .addr_lsb_m(addr_lsb_m),
      .bypass_data_m(bypass_data_m), .bypass_valid_m(bypass_valid_m), .interlock_m(interlock_m),
      .result_w(result_w), .write_idx_w(write_idx_w), .write_enable_w(write_enable_w),
      .valid_w(valid_w)
   );

   lm32_m_result_stage #(.MULTIPLIER_ENABLED(1'b0), .BYPASS_ENABLED(1'b0)) dutNoMul (
      .clk_i(clk), .rst_i(rst), .stall_m(stall_m), .kill_m(kill_m), .valid_m(valid_m),
      .write_enable_m(write_enable_m), .write_idx_m(write_idx_m), .result_sel_m(result_sel_m),
      .operand_m(operand_m), .shifter_result_m(shifter_result_m),
      .multiplier_result_m(multiplier_result_m), .load_data_m(load_data_m),
      .load_size_m(load_size_m), .load_sign_extend_m(load_sign_extend_m), .addr_lsb_m(addr_lsb_m),
      .bypass_data_m(bypass_data_m2), .bypass_valid_m(bypass_valid_m2), .interlock_m(interlock_m2),
      .result_w(result_w2), .write_idx_w(write_idx_w2), .write_enable_w(write_enable_w2),
      .valid_w(valid_w2)
   );

   function automatic vec_t mk(input logic valid, input logic we, input logic kill,
                               input logic [4:0] idx, input logic [1:0] sel,
                               input logic [1:0] size, input logic sign, input logic [1:0] addr,
                               input logic [31:0] op, input logic [31:0] sh,
                               input logic [31:0] mul, input logic [31:0] ld,
                               input logic expBv, input logic expIl,
                               input logic [31:0] expRw, input logic expVw, input logic expWw);
      vec_t v;
      v.valid = valid; v.we = we; v.kill = kill; v.idx = idx; v.sel = sel;
      v.size = size; v.sign = sign; v.addr = addr;
      v.op = op; v.sh = sh; v.mul = mul; v.ld = ld;
      v.expBv = expBv; v.expIl = expIl; v.expRw = expRw; v.expVw = expVw; v.expWw = expWw;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input logic stall);
      stall_m = stall; kill_m = v.kill; valid_m = v.valid; write_enable_m = v.we;
      write_idx_m = v.idx; result_sel_m = v.sel; load_size_m = v.size;
      load_sign_extend_m = v.sign; addr_lsb_m = v.addr;
      operand_m = v.op; shifter_result_m = v.sh; multiplier_result_m = v.mul; load_data_m = v.ld;
   endtask

   task automatic checkWZero(input string tag);
      checkOutput({tag, "_result_w"}, result_w, 32'h0);
      checkOutput({tag, "_idx_w"}, {27'h0, write_idx_w}, 32'h0);
      checkOutput({tag, "_we_w"}, {31'h0, write_enable_w}, 32'h0);
      checkOutput({tag, "_valid_w"}, {31'h0, valid_w}, 32'h0);
   endtask

   initial begin
      vec_t v;
      logic [31:0] expBd;
      rst = 1'b1;
      v = mk(0,0,0, 5'd0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(v, 1'b0);

      // valid, we, kill, idx, sel, size, sign, addr, op, sh, mul, ld, bv, il, rw, vw, ww
      vecs.push_back(mk(1,1,0, 5'd7,  2'b01, 2'b10, 0, 2'b00, 32'h0, 32'hF000_0001, 32'h0, 32'h0, 1,0, 32'hF000_0001, 1,1));
      vecs.push_back(mk(1,1,0, 5'd3,  2'b11, 2'b00, 1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h8012_3456, 0,1, 32'hFFFF_FF80, 1,1));
      vecs.push_back(mk(1,1,0, 5'd3,  2'b11, 2'b00, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h8012_3456, 0,1, 32'h0000_0080, 1,1));
      vecs.push_back(mk(1,1,0, 5'd3,  2'b11, 2'b00, 1, 2'b11, 32'h0, 32'h0, 32'h0, 32'h8012_3456, 0,1, 32'h0000_0056, 1,1));
      vecs.push_back(mk(1,1,0, 5'd4,  2'b11, 2'b00, 0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h8012_3456, 0,1, 32'h0000_0012, 1,1));
      vecs.push_back(mk(1,1,0, 5'd4,  2'b11, 2'b00, 0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h8012_3456, 0,1, 32'h0000_0034, 1,1));
      vecs.push_back(mk(1,1,0, 5'd5,  2'b11, 2'b01, 1, 2'b10, 32'h0, 32'h0, 32'h0, 32'hABCD_7FFF, 0,1, 32'h0000_7FFF, 1,1));
      vecs.push_back(mk(1,1,0, 5'd5,  2'b11, 2'b01, 1, 2'b00, 32'h0, 32'h0, 32'h0, 32'hABCD_7FFF, 0,1, 32'hFFFF_ABCD, 1,1));
      vecs.push_back(mk(1,1,0, 5'd5,  2'b11, 2'b01, 0, 2'b01, 32'h0, 32'h0, 32'h0, 32'hABCD_7FFF, 0,1, 32'h0000_ABCD, 1,1));
      vecs.push_back(mk(1,1,0, 5'd5,  2'b11, 2'b00, 1, 2'b00, 32'h0, 32'h0, 32'h0, 32'hABCD_7FFF, 0,1, 32'hFFFF_FFAB, 1,1));
      vecs.push_back(mk(1,1,0, 5'd6,  2'b11, 2'b10, 1, 2'b11, 32'h0, 32'h0, 32'h0, 32'hABCD_7FFF, 0,1, 32'hABCD_7FFF, 1,1));
      vecs.push_back(mk(1,1,0, 5'd6,  2'b11, 2'b11, 1, 2'b01, 32'h0, 32'h0, 32'h0, 32'h8BCD_7FFF, 0,1, 32'h8BCD_7FFF, 1,1));
      vecs.push_back(mk(1,1,0, 5'd8,  2'b10, 2'b10, 0, 2'b00, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 1,0, 32'h1234_5678, 1,1));
      vecs.push_back(mk(1,0,0, 5'd9,  2'b00, 2'b10, 0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 0,0, 32'hDEAD_BEEF, 1,0));
      vecs.push_back(mk(1,1,1, 5'd10, 2'b00, 2'b10, 0, 2'b00, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 1,0, 32'h1111_2222, 0,0));
      vecs.push_back(mk(0,1,0, 5'd11, 2'b11, 2'b10, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h5555_AAAA, 0,0, 32'h5555_AAAA, 0,0));
      vecs.push_back(mk(1,1,0, 5'd0,  2'b00, 2'b10, 0, 2'b00, 32'h0000_0042, 32'h0, 32'h0, 32'h0, 1,0, 32'h0000_0042, 1,1));

      #2;
      checkWZero("reset");
      @(negedge clk);
      rst = 1'b0;
      #1 checkWZero("reset_release");

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i], 1'b0);
         expBd = vecs[i].expRw;
         #1;
         checkOutput($sformatf("v%0d_bypass_valid", i), {31'h0, bypass_valid_m}, {31'h0, vecs[i].expBv});
         checkOutput($sformatf("v%0d_bypass_data", i), bypass_data_m, expBd);
         checkOutput($sformatf("v%0d_interlock", i), {31'h0, interlock_m}, {31'h0, vecs[i].expIl});
         checkOutput($sformatf("v%0d_nobyp_valid", i), {31'h0, bypass_valid_m2}, 32'h0);
         checkOutput($sformatf("v%0d_nobyp_data", i), bypass_data_m2, 32'h0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_result_w", i), result_w, vecs[i].expRw);
         checkOutput($sformatf("v%0d_idx_w", i), {27'h0, write_idx_w}, {27'h0, vecs[i].idx});
         checkOutput($sformatf("v%0d_valid_w", i), {31'h0, valid_w}, {31'h0, vecs[i].expVw});
         checkOutput($sformatf("v%0d_we_w", i), {31'h0, write_enable_w}, {31'h0, vecs[i].expWw});
         checkOutput($sformatf("v%0d_nomul_result_w", i), result_w2,
                     (vecs[i].sel == 2'b10) ? 32'h0 : vecs[i].expRw);
      end

      // Stall: three bubble cycles hold result/index, then the stalled instruction lands.
      @(negedge clk);
      applyStimulus(mk(1,1,0, 5'd9, 2'b00, 2'b10, 0, 2'b00, 32'hAAAA_0001, 0, 0, 0, 0,0, 0, 0,0), 1'b0);
      @(posedge clk);
      #1 checkOutput("stall_pre_result_w", result_w, 32'hAAAA_0001);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         applyStimulus(mk(1,1,(c == 1), 5'd12, 2'b00, 2'b10, 0, 2'b00, 32'hBBBB_0002, 0, 0, 0, 0,0, 0, 0,0), 1'b1);
         if (c == 2) begin
            result_sel_m = 2'b11;
            #1 checkOutput("stall_interlock", {31'h0, interlock_m}, 32'h1);
            result_sel_m = 2'b00;
         end
         @(posedge clk);
         #1;
         checkOutput($sformatf("stall%0d_result_w", c), result_w, 32'hAAAA_0001);
         checkOutput($sformatf("stall%0d_idx_w", c), {27'h0, write_idx_w}, 32'd9);
         checkOutput($sformatf("stall%0d_valid_w", c), {31'h0, valid_w}, 32'h0);
         checkOutput($sformatf("stall%0d_we_w", c), {31'h0, write_enable_w}, 32'h0);
      end
      @(negedge clk);
      stall_m = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("release_result_w", result_w, 32'hBBBB_0002);
      checkOutput("release_idx_w", {27'h0, write_idx_w}, 32'd12);
      checkOutput("release_valid_w", {31'h0, valid_w}, 32'h1);
      checkOutput("release_we_w", {31'h0, write_enable_w}, 32'h1);

      // Asynchronous reset between edges, held across an edge, then released.
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkWZero("async_rst");
      @(posedge clk);
      #1 checkWZero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      #1 checkWZero("rst_after_release");
      @(posedge clk);
      #1;
      checkOutput("first_capture_result_w", result_w, 32'hBBBB_0002);
      checkOutput("first_capture_valid_w", {31'h0, valid_w}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
